// File: rtl/packed_word_serializer.sv
// packed_word_serializer: splits one IN_W-bit word into ceil(IN_W/OUT_W) OUT_W-bit beats, LSB beat first, last beat zero-padded.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_bits    : packed word input handshake
//   out_valid/out_ready/out_bits : beat output handshake
//   out_last       : marks beat BEATS-1
//   PACKED_SER_PIPE_EN (define) : accept the next word during the last-beat handshake (adds out_ready->in_ready path)
module packed_word_serializer #(
  parameter int IN_W  = 126,
  parameter int OUT_W = 32,
  localparam int BEATS = (IN_W + OUT_W - 1) / OUT_W,
  localparam int CW    = $clog2(BEATS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_bits,
  output logic             out_last
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [IN_W-1:0] word;
  logic [CW-1:0] cnt;
  logic [BEATS*OUT_W-1:0] flat;
  logic [BEATS-1:0][OUT_W-1:0] pad;
  logic last_beat;
  always_comb begin
    flat = '0;
    flat[IN_W-1:0] = word;
  end
  assign pad       = flat;
  assign last_beat = cnt == CW'(BEATS - 1);
  assign out_valid = state == SEND;
  assign out_bits  = out_valid ? pad[cnt] : '0;
  assign out_last  = out_valid && last_beat;
`ifdef PACKED_SER_PIPE_EN
  assign in_ready = state == IDLE || (last_beat && out_ready && out_valid);
`else
  assign in_ready = state == IDLE;
`endif
  // a load wins over beat advance so the pipelined variant can chain words
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      word  <= '0;
      cnt   <= '0;
    end else if (in_valid && in_ready) begin
      state <= SEND;
      word  <= in_bits;
      cnt   <= '0;
    end else if (out_valid && out_ready) begin
      state <= last_beat ? IDLE : SEND;
      cnt   <= last_beat ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_packed_word_serializer.sv
// tb_packed_word_serializer: directed self-checking bench for packed_word_serializer.
module tb_packed_word_serializer;
  logic clock = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic [125:0] in_bits = '0;
  logic in_ready, out_valid, out_last;
  logic [31:0] out_bits;
  int n_run = 0, n_fail = 0;
  logic [125:0] w1, w2, w3;
  logic [3:0][31:0] b1, b2, b3;
  packed_word_serializer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .out_last(out_last)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic check_beat(input string tag, input logic [31:0] b, input logic l);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " bits"}, out_bits, b);
    chk({tag, " last"}, 32'(out_last), 32'(l));
`ifdef PACKED_SER_PIPE_EN
    chk({tag, " in_ready"}, 32'(in_ready), 32'(l && out_ready));
`else
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
`endif
  endtask
  task automatic run_word(input string tag, input logic [125:0] w, input logic [3:0][31:0] b);
    in_valid = 1;
    in_bits = w;
    chk({tag, " accept"}, 32'(in_ready), 32'd1);
    tick;
    in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      check_beat($sformatf("%s beat%0d", tag, k), b[k], k == 3);
      tick;
    end
    chk({tag, " done valid"}, 32'(out_valid), 32'd0);
    chk({tag, " done in_ready"}, 32'(in_ready), 32'd1);
  endtask
  initial begin
    w1 = {30'h3FFF_FFFF, 32'h33, 32'h22, 32'h11};
    b1 = {32'h3FFF_FFFF, 32'h33, 32'h22, 32'h11};
    w2 = {30'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0BAD_C0DE};
    b2 = {32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0BAD_C0DE};
    w3 = '1;
    b3 = {32'h3FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tick;
    tick;
    reset = 0;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_bits", out_bits, 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    run_word("single", w1, b1);
    in_valid = 1;
    in_bits = w1;
    tick;
    in_valid = 0;
    check_beat("bp beat0", b1[0], 0);
    tick;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      check_beat($sformatf("bp hold%0d", i), b1[1], 0);
      tick;
    end
    out_ready = 1;
    check_beat("bp resume1", b1[1], 0);
    tick;
    check_beat("bp beat2", b1[2], 0);
    tick;
    check_beat("bp beat3", b1[3], 1);
    tick;
    chk("bp done", 32'(out_valid), 32'd0);
    in_valid = 1;
    in_bits = w1;
    tick;
    for (int k = 0; k < 4; k++) begin
      in_bits = (k == 3) ? w2 : {4{32'h5A5A_0000 + 32'(k)}} >> 2;
      check_beat($sformatf("busy beat%0d", k), b1[k], k == 3);
      tick;
    end
`ifndef PACKED_SER_PIPE_EN
    chk("b2b bubble valid", 32'(out_valid), 32'd0);
    chk("b2b bubble in_ready", 32'(in_ready), 32'd1);
    tick;
`endif
    in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      check_beat($sformatf("b2b w2 beat%0d", k), b2[k], k == 3);
      tick;
    end
    chk("b2b done", 32'(out_valid), 32'd0);
    in_valid = 1;
    in_bits = w2;
    tick;
    in_valid = 0;
    tick;
    tick;
    check_beat("rst mid beat2", b2[2], 0);
    reset = 1;
    tick;
    reset = 0;
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst out_last", 32'(out_last), 32'd0);
    chk("mid rst in_ready", 32'(in_ready), 32'd1);
    chk("mid rst out_bits", out_bits, 32'd0);
    run_word("after rst", w1, b1);
    run_word("all ones", w3, b3);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/packed_word_serializer.md
# packed_word_serializer

Downstream consumer of the flattened bundle-vector word: accepts one packed `IN_W`-bit word per valid/ready handshake and emits it as `ceil(IN_W/OUT_W)` narrower beats on a valid/ready output with a last-beat flag. It sits directly after the bundle-flattening stage (126-bit packed word) and feeds a 32-bit link or FIFO. LSB beat first; the final beat is zero-padded.

## Interface

- `IN_W`, 126, packed input word width; must be ≥ 2·`OUT_W`.
- `OUT_W`, 32, output beat width.
- Derived: `BEATS = ceil(IN_W/OUT_W)` (4 at defaults); `CW = clog2(BEATS)` (2 at defaults).

Ports:

- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: packed word present.
- `in_ready` output 1: word accepted when `in_valid && in_ready`.
- `in_bits` input `IN_W`: packed word, bit 0 = LSB of the flattened bundle.
- `out_valid` output 1: beat present.
- `out_ready` input 1: beat consumed when `out_valid && out_ready`.
- `out_bits` output `OUT_W`: current beat.
- `out_last` output 1: high on beat `BEATS-1` only, qualified by `out_valid`.

## Operation

- State: `IDLE`, `SEND`. Registers: `word[IN_W-1:0]`, `cnt[CW-1:0]`.
- `IDLE`:
  - `in_ready=1`, `out_valid=0`.
  - On input handshake: `word<=in_bits`, `cnt<=0`, go to `SEND`.
- `SEND`:
  - `out_valid=1`, `out_bits = word[cnt*OUT_W +: OUT_W]`; bits above `IN_W-1` read as 0.
  - `out_last = (cnt==BEATS-1)`.
  - On output handshake with `cnt<BEATS-1`: `cnt<=cnt+1`.
  - On output handshake with `cnt==BEATS-1`: go to `IDLE`, `cnt<=0`. See Configuration for the pipelined variant.
- No output handshake: `out_bits`, `out_last` and `cnt` hold stable; `out_valid` never drops once raised until the beat is taken.
- `in_valid` while busy: ignored (`in_ready=0`); the upstream must hold the word.
- Reset at any time, including mid-word: the partial word is discarded, no further beats are emitted, and the block returns to `IDLE`.
- Reset values: `in_ready=1` (first cycle after reset release), `out_valid=0`, `out_bits=0`, `out_last=0`, `word=0`, `cnt=0`, state `IDLE`.

## Timing

- Latency: input handshake in cycle t → beat 0 valid in cycle t+1.
- Beat k follows beat k-1 in the cycle after its handshake; a full word with `out_ready` held high occupies cycles t+1 .. t+`BEATS`.
- Throughput without the feature: one word per `BEATS+1` cycles (1 idle bubble).
- `in_ready` in base build is a pure function of state (registered path); no combinational in→out path.

## Configuration

- `PACKED_SER_PIPE_EN`: when defined, `in_ready` is also asserted in `SEND` when `cnt==BEATS-1 && out_ready`. This is a combinational `out_ready`→`in_ready` path.
- With it, a simultaneous last-beat handshake and input handshake loads `word<=in_bits`, `cnt<=0`, and the block stays in `SEND`. Throughput is one word per `BEATS` cycles with no bubble.
- Without it, the base behaviour applies: `in_ready` only in `IDLE`.

## Test plan

- Reset, then single word: `in_bits[31:0]=32'h11`, `[63:32]=32'h22`, `[95:64]=32'h33`, `[125:96]=30'h3FFF_FFFF`, `out_ready=1` → beats `32'h11`, `32'h22`, `32'h33`, `32'h3FFF_FFFF` on 4 consecutive cycles starting t+1; `out_last` set only on the 4th beat; `in_ready` low t+1..t+4.
- Backpressure: same word, `out_ready` low for 3 cycles during beat 1 → `out_bits` held at `32'h22`, `out_valid=1`, `cnt` unchanged; stream resumes with `32'h33`.
- Back-to-back words with `in_valid` held high, base build → second word's beat 0 appears 5 cycles after the first word's beat 0. With `PACKED_SER_PIPE_EN` → 4 cycles, and `in_ready` pulses in the last-beat cycle.
- `in_valid` asserted while busy with changing `in_bits` → beats of the first word are unaffected; the new word is taken only when `in_ready=1`.
- Reset asserted during beat 2 → next cycle `out_valid=0`, `out_last=0`, `in_ready=1`; a following word starts again at beat 0.
- All-ones input word → last beat equals `32'h3FFF_FFFF` (pad bits 31:30 zero).
